// File: rtl/dst_reg_pipe_pkg.sv
// rtl/dst_reg_pipe_pkg.sv - shared select codes, link register, forward encoding, clog2
package dst_reg_pipe_pkg;

  typedef enum logic [1:0] {
    SEL_RT   = 2'b00,
    SEL_R31  = 2'b01,
    SEL_RD   = 2'b10,
    SEL_NONE = 2'b11
  } sel_e;

  localparam int LINK_REG = 31;

  // Forward select: 0 reads the register file, k takes the result held in stage k
  localparam int FWD_RF = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dst_reg_pipe_if.sv
// rtl/dst_reg_pipe_if.sv - decode-side and hazard-side signal bundle for dst_reg_pipe
interface dst_reg_pipe_if
  import dst_reg_pipe_pkg::*;
#(
  parameter int NBITS   = 5,
  parameter int SELBITS = 2,
  parameter int NSTAGES = 3,
  localparam int FWDBITS = clog2(NSTAGES + 1)
);
  logic [NBITS-1:0]         reg_rt;
  logic [NBITS-1:0]         reg_rd;
  logic [SELBITS-1:0]       sel_reg;
  logic                     reg_write;
  logic                     mem_read;
  logic [NBITS-1:0]         src_rs;
  logic [NBITS-1:0]         src_rt;
  logic                     stall;
  logic                     flush;
  logic [NSTAGES*NBITS-1:0] dst_reg;
  logic [NSTAGES-1:0]       dst_valid;
  logic [FWDBITS-1:0]       fwd_a;
  logic [FWDBITS-1:0]       fwd_b;
  logic                     load_use;

  modport master (
    output reg_rt, reg_rd, sel_reg, reg_write, mem_read, src_rs, src_rt, stall, flush,
    input  dst_reg, dst_valid, fwd_a, fwd_b, load_use
  );

  modport slave (
    input  reg_rt, reg_rd, sel_reg, reg_write, mem_read, src_rs, src_rt, stall, flush,
    output dst_reg, dst_valid, fwd_a, fwd_b, load_use
  );
endinterface

// File: rtl/dst_stage_reg.sv
// rtl/dst_stage_reg.sv - one pipeline slot: destination, write-valid and load flag flops
module dst_stage_reg #(
  parameter int NBITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] i_dst,
  input  logic             i_valid,
  input  logic             i_load,
  output logic [NBITS-1:0] o_dst,
  output logic             o_valid,
  output logic             o_load
);
  logic [NBITS-1:0] r_dst;
  logic             r_valid;
  logic             r_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dst   <= '0;
      r_valid <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_dst   <= i_dst;
      r_valid <= i_valid;
      r_load  <= i_load;
    end
  end

  assign o_dst   = r_dst;
  assign o_valid = r_valid;
  assign o_load  = r_load;
endmodule

// File: rtl/dst_reg_pipe.sv
// rtl/dst_reg_pipe.sv - tracks in-flight destination registers and derives forwarding and load-use hazards
module dst_reg_pipe
  import dst_reg_pipe_pkg::*;
#(
  parameter int NBITS   = 5,
  parameter int SELBITS = 2,
  parameter int NSTAGES = 3,
  localparam int FWDBITS = clog2(NSTAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NBITS-1:0]         reg_rt,
  input  logic [NBITS-1:0]         reg_rd,
  input  logic [SELBITS-1:0]       sel_reg,
  input  logic                     reg_write,
  input  logic                     mem_read,
  input  logic [NBITS-1:0]         src_rs,
  input  logic [NBITS-1:0]         src_rt,
  input  logic                     stall,
  input  logic                     flush,
  output logic [NSTAGES*NBITS-1:0] dst_reg,
  output logic [NSTAGES-1:0]       dst_valid,
  output logic [FWDBITS-1:0]       fwd_a,
  output logic [FWDBITS-1:0]       fwd_b,
  output logic                     load_use
);
  logic [NBITS-1:0] w_entry_dst;
  logic             w_sel_ok;
  logic             w_bubble;

  logic [NBITS-1:0] w_d_dst   [NSTAGES];
  logic             w_d_valid [NSTAGES];
  logic             w_d_load  [NSTAGES];
  logic [NBITS-1:0] w_q_dst   [NSTAGES];
  logic             w_q_valid [NSTAGES];
  logic             w_q_load  [NSTAGES];

  logic [FWDBITS-1:0] w_fwd_a;
  logic [FWDBITS-1:0] w_fwd_b;

  always_comb begin
    w_entry_dst = '0;
    w_sel_ok    = 1'b1;
    case (sel_reg)
      SELBITS'(SEL_RT):  w_entry_dst = reg_rt;
      SELBITS'(SEL_R31): w_entry_dst = NBITS'(LINK_REG);
      SELBITS'(SEL_RD):  w_entry_dst = reg_rd;
      default:           w_sel_ok    = 1'b0;
    endcase
  end

  // Stall and flush both collapse to the same bubble at stage 1; older stages keep moving
  assign w_bubble = stall | flush;

  genvar g;
  generate
    for (g = 0; g < NSTAGES; g++) begin : g_stage
      if (g == 0) begin : g_head
        assign w_d_dst[g]   = w_bubble ? '0 : w_entry_dst;
        assign w_d_valid[g] = !w_bubble && reg_write && w_sel_ok && (w_entry_dst != '0);
        assign w_d_load[g]  = !w_bubble && mem_read;
      end else begin : g_body
        assign w_d_dst[g]   = w_q_dst[g-1];
        assign w_d_valid[g] = w_q_valid[g-1];
        assign w_d_load[g]  = w_q_load[g-1];
      end

      dst_stage_reg #(.NBITS(NBITS)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_dst   (w_d_dst[g]),
        .i_valid (w_d_valid[g]),
        .i_load  (w_d_load[g]),
        .o_dst   (w_q_dst[g]),
        .o_valid (w_q_valid[g]),
        .o_load  (w_q_load[g])
      );

      assign dst_reg[g*NBITS +: NBITS] = w_q_dst[g];
      assign dst_valid[g]              = w_q_valid[g];
    end
  endgenerate

  // Scan oldest to youngest so the youngest matching stage overwrites and wins
  always_comb begin
    w_fwd_a = FWDBITS'(FWD_RF);
    w_fwd_b = FWDBITS'(FWD_RF);
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (w_q_valid[k] && (src_rs != '0) && (w_q_dst[k] == src_rs)) w_fwd_a = FWDBITS'(k + 1);
      if (w_q_valid[k] && (src_rt != '0) && (w_q_dst[k] == src_rt)) w_fwd_b = FWDBITS'(k + 1);
    end
  end

  assign fwd_a    = w_fwd_a;
  assign fwd_b    = w_fwd_b;
  assign load_use = w_q_valid[0] && w_q_load[0] &&
                    (((src_rs != '0) && (w_q_dst[0] == src_rs)) ||
                     ((src_rt != '0) && (w_q_dst[0] == src_rt)));
endmodule

// File: tb/tb_dst_reg_pipe.sv
// tb/tb_dst_reg_pipe.sv - scoreboard bench for dst_reg_pipe with a queue-based pipeline model
module tb_dst_reg_pipe;
  localparam int N  = 5;
  localparam int S  = 2;
  localparam int NS = 3;
  localparam int FB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dst_reg_pipe_if #(.NBITS(N), .SELBITS(S), .NSTAGES(NS)) bus ();

  dst_reg_pipe #(.NBITS(N), .SELBITS(S), .NSTAGES(NS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_rt    (bus.reg_rt),
    .reg_rd    (bus.reg_rd),
    .sel_reg   (bus.sel_reg),
    .reg_write (bus.reg_write),
    .mem_read  (bus.mem_read),
    .src_rs    (bus.src_rs),
    .src_rt    (bus.src_rt),
    .stall     (bus.stall),
    .flush     (bus.flush),
    .dst_reg   (bus.dst_reg),
    .dst_valid (bus.dst_valid),
    .fwd_a     (bus.fwd_a),
    .fwd_b     (bus.fwd_b),
    .load_use  (bus.load_use)
  );

  typedef struct {
    logic [NS*N-1:0] dst;
    logic [NS-1:0]   val;
    logic [FB-1:0]   fa;
    logic [FB-1:0]   fb;
    logic            lu;
    string           tag;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  bit stim_done = 0;

  // Reference pipeline: index 1 is the youngest in-flight instruction
  int m_dst [1:NS];
  bit m_val [1:NS];
  bit m_ld  [1:NS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int fwd_of(input int src);
    if (src == 0) return 0;
    for (int k = 1; k <= NS; k++)
      if (m_val[k] && m_dst[k] == src) return k;
    return 0;
  endfunction

  function automatic exp_t predict(input int rs, input int rt, input string tag);
    exp_t e;
    e.dst = '0;
    e.val = '0;
    for (int k = 1; k <= NS; k++) begin
      e.dst[(k-1)*N +: N] = N'(m_dst[k]);
      e.val[k-1]          = m_val[k];
    end
    e.fa  = FB'(fwd_of(rs));
    e.fb  = FB'(fwd_of(rt));
    e.lu  = m_val[1] && m_ld[1] &&
            ((rs != 0 && m_dst[1] == rs) || (rt != 0 && m_dst[1] == rt));
    e.tag = tag;
    return e;
  endfunction

  function automatic void model_clear();
    for (int k = 1; k <= NS; k++) begin
      m_dst[k] = 0;
      m_val[k] = 0;
      m_ld[k]  = 0;
    end
  endfunction

  function automatic void model_advance(input int rt, input int rd, input int sel,
                                        input bit wr, input bit mr, input bit bub);
    int d;
    for (int k = NS; k >= 2; k--) begin
      m_dst[k] = m_dst[k-1];
      m_val[k] = m_val[k-1];
      m_ld[k]  = m_ld[k-1];
    end
    d = (sel == 0) ? rt : (sel == 1) ? 31 : (sel == 2) ? rd : 0;
    m_dst[1] = bub ? 0 : d;
    m_val[1] = !bub && wr && d != 0 && sel != 3;
    m_ld[1]  = !bub && mr;
  endfunction

  // One cycle: drive after the edge, record what the DUT must show now, then advance the model
  task automatic step(input string tag, input int sel, input int rt, input int rd,
                      input bit wr, input bit mr, input int rs, input int srt,
                      input bit stl, input bit fl);
    @(posedge clk);
    #1;
    bus.sel_reg = S'(sel); bus.reg_rt = N'(rt); bus.reg_rd = N'(rd);
    bus.reg_write = wr; bus.mem_read = mr; bus.src_rs = N'(rs); bus.src_rt = N'(srt);
    bus.stall = stl; bus.flush = fl;
    exp_q.push_back(predict(rs, srt, tag));
    model_advance(rt, rd, sel, wr, mr, stl | fl);
  endtask

  task automatic idle(input string tag, input int rs, input int srt, input bit stl);
    step(tag, 0, 0, 0, 0, 0, rs, srt, stl, 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    bus.sel_reg = '0; bus.reg_rt = '0; bus.reg_rd = '0; bus.reg_write = 0; bus.mem_read = 0;
    bus.src_rs = N'(9); bus.src_rt = N'(9); bus.stall = 0; bus.flush = 0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(bus.dst_valid), 32'd0);
    chk("async_reset_dst", 32'(bus.dst_reg), 32'd0);
    model_clear();
    exp_q.push_back(predict(9, 9, "in_reset"));
    #6;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, "_dst"},   32'(bus.dst_reg),   32'(e.dst));
        chk({e.tag, "_valid"}, 32'(bus.dst_valid), 32'(e.val));
        chk({e.tag, "_fwd_a"}, 32'(bus.fwd_a),     32'(e.fa));
        chk({e.tag, "_fwd_b"}, 32'(bus.fwd_b),     32'(e.fb));
        chk({e.tag, "_ld_use"}, 32'(bus.load_use), 32'(e.lu));
      end
    end
  end

  initial begin : stimulus
    int sel, rt, rd, rs, srt;
    bit wr, mr, stl, fl;
    bus.sel_reg = '0; bus.reg_rt = '0; bus.reg_rd = '0; bus.reg_write = 0; bus.mem_read = 0;
    bus.src_rs = '0; bus.src_rt = '0; bus.stall = 0; bus.flush = 0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("por_valid", 32'(bus.dst_valid), 32'd0);
    chk("por_dst", 32'(bus.dst_reg), 32'd0);
    chk("por_fwd", 32'({bus.fwd_a, bus.fwd_b, bus.load_use}), 32'd0);
    rst_n = 1'b1;

    step("walk_issue", 2, 0, 7, 1, 0, 0, 0, 0, 0);
    idle("walk1", 7, 0, 0);
    idle("walk2", 7, 0, 0);
    idle("walk3", 7, 0, 0);
    idle("walk_out", 7, 0, 0);

    step("link", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    step("sel11", 3, 4, 4, 1, 0, 31, 0, 0, 0);
    step("rd0", 2, 0, 0, 1, 0, 31, 0, 0, 0);
    idle("after_rd0", 31, 0, 0);

    step("r5_a", 2, 0, 5, 1, 0, 0, 0, 0, 0);
    step("r5_b", 2, 0, 5, 1, 0, 0, 0, 0, 0);
    idle("fwd_s1", 5, 0, 1);
    idle("fwd_s2", 5, 0, 0);

    step("load_r9", 0, 9, 0, 1, 1, 0, 0, 0, 0);
    idle("load_use", 0, 9, 0);
    step("both_kill", 2, 0, 12, 1, 0, 0, 0, 1, 1);
    idle("no_src", 0, 0, 0);
    step("stall_only", 2, 0, 13, 1, 1, 13, 0, 1, 0);
    step("flush_only", 2, 0, 14, 1, 1, 14, 0, 0, 1);
    idle("bubbles", 13, 14, 0);

    step("fill1", 2, 0, 3, 1, 0, 0, 0, 0, 0);
    step("fill2", 0, 4, 0, 1, 0, 0, 0, 0, 0);
    step("fill3", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    idle("full", 3, 4, 0);
    reset_pulse();
    idle("post_reset", 3, 4, 0);
    step("restart", 2, 0, 12, 1, 0, 12, 0, 0, 0);
    idle("restart_s1", 12, 12, 0);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 3);
      rt  = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7);
      rd  = $urandom_range(0, 7);
      wr  = ($urandom_range(0, 3) != 0);
      mr  = ($urandom_range(0, 2) == 0);
      rs  = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7);
      srt = $urandom_range(0, 7);
      stl = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      step("rand", sel, rt, rd, wr, mr, rs, srt, stl, fl);
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
